// File: rtl/packet_arbiter_pkg.sv
// Shared types and constants for the packet arbiter: FSM states, the header
// magic byte and the header word builder.
package packet_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef logic [31:0] word_t;

  // Sequence counts narrower than 16 bits arrive zero-extended, which gives the middle padding.
  function automatic word_t hdr_word(input logic [7:0] src, input logic [15:0] seq);
    return {HDR_MAGIC, src, seq};
  endfunction

endpackage

// File: rtl/packet_arbiter_rr_priority.sv
// Combinational round-robin pick: the first set request found scanning
// upward from ptr_i with wrap-around. Kept generic for reuse by other arbiters.
module rr_priority #(
  parameter int M = 4
) (
  input  logic [M-1:0]         req_i,
  input  logic [$clog2(M)-1:0] ptr_i,
  output logic                 any_o,
  output logic [$clog2(M)-1:0] idx_o
);

  localparam int IW = $clog2(M);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx_o = '0;
    for (int k = 0; k < M; k++) begin
      cand = IW'((int'(ptr_i) + k) % M);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter merging M word streams onto one output.
// Define PACKET_ARBITER_HEADER_EN to prefix each packet with a source/sequence header.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int M     = 4,
  parameter int SEQ_W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  word_t        in_data [M],
  input  logic [M-1:0] in_valid,
  input  logic [M-1:0] in_last,
  output logic [M-1:0] upstream_stall,
  output word_t        out_data,
  output logic         out_valid,
  input  logic         downstream_stall
);

  localparam int IW = $clog2(M);
  localparam logic [IW-1:0] LastIdx = IW'(M - 1);
  localparam logic [IW-1:0] OneIdx  = IW'(1);

  if (M < 2 || M > 16 || SEQ_W < 1 || SEQ_W > 16) begin : gBadParams
    $error("packet_arbiter: M must be 2..16 and SEQ_W 1..16");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rrPtr_q, rrPtr_d;
  logic [IW-1:0] pickIdx;
  logic          pickAny;
  logic          lastXfer;
`ifdef PACKET_ARBITER_HEADER_EN
  logic [SEQ_W-1:0] seq_q, seq_d;
`endif

  rr_priority #(.M(M)) uPick (
    .req_i (in_valid),
    .ptr_i (rrPtr_q),
    .any_o (pickAny),
    .idx_o (pickIdx)
  );

  assign lastXfer = in_valid[grant_q] && !downstream_stall && in_last[grant_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rrPtr_q <= '0;
`ifdef PACKET_ARBITER_HEADER_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rrPtr_q <= rrPtr_d;
`ifdef PACKET_ARBITER_HEADER_EN
      seq_q   <= seq_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rrPtr_d = rrPtr_q;
`ifdef PACKET_ARBITER_HEADER_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          grant_d = pickIdx;
`ifdef PACKET_ARBITER_HEADER_EN
          state_d = HDR;
`else
          state_d = BURST;
`endif
        end
      end
`ifdef PACKET_ARBITER_HEADER_EN
      HDR: begin
        if (!downstream_stall) state_d = BURST;
      end
`endif
      BURST: begin
        // Advancing the pointer past the winner is what stops it winning twice in a row.
        if (lastXfer) begin
          state_d = IDLE;
          rrPtr_d = (grant_q == LastIdx) ? '0 : grant_q + OneIdx;
`ifdef PACKET_ARBITER_HEADER_EN
          seq_d   = seq_q + SEQ_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid      = 1'b0;
    out_data       = '0;
    upstream_stall = '1;
    case (state_q)
`ifdef PACKET_ARBITER_HEADER_EN
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_word(8'(grant_q), 16'(seq_q));
      end
`endif
      BURST: begin
        out_valid               = in_valid[grant_q];
        out_data                = in_data[grant_q];
        upstream_stall[grant_q] = downstream_stall;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed self-checking bench for packet_arbiter (M=4). Header scenarios run
// only when PACKET_ARBITER_HEADER_EN is defined, with SEQ_W=4 to reach the wrap.
module tb_packet_arbiter;

`ifdef PACKET_ARBITER_HEADER_EN
  localparam int SeqW = 4;
`else
  localparam int SeqW = 16;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inData [4];
  logic [3:0]  inValid;
  logic [3:0]  inLast;
  logic [3:0]  upstreamStall;
  logic [31:0] outData;
  logic        outValid;
  logic        downstreamStall;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  packet_arbiter #(.M(4), .SEQ_W(SeqW)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_data          (inData),
    .in_valid         (inValid),
    .in_last          (inLast),
    .upstream_stall   (upstreamStall),
    .out_data         (outData),
    .out_valid        (outValid),
    .downstream_stall (downstreamStall)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    inValid         = '0;
    inLast          = '0;
    downstreamStall = 1'b0;
    for (int i = 0; i < 4; i++) inData[i] = '0;
  endtask

  // Header builds spend one extra cycle per packet on the header word.
  task automatic skipHeader(input logic [7:0] src);
`ifdef PACKET_ARBITER_HEADER_EN
    #1;
    checks++;
    if (!(outValid === 1'b1 && outData[31:16] === {8'hA5, src})) begin
      failures++;
      $display("[TB] FAIL hdr_prefix actual valid=%b data=%h required prefix=a5%h", outValid, outData, src);
    end
    step();
`else
    if (src > 8'd15) $display("[TB] unexpected source %0d", src);
`endif
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b1;
    step();
    step();
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b required=0", outValid); end
    checks++; if (outData !== 32'h0) begin failures++; $display("[TB] FAIL reset_data actual=%h required=0", outData); end
    checks++; if (upstreamStall !== 4'hF) begin failures++; $display("[TB] FAIL reset_stall actual=%b required=1111", upstreamStall); end
    reset = 1'b0;
  endtask

  task automatic test_single_source();
    inValid = 4'b0100; inData[2] = 32'h11;
    #1;
    checks++; if (outValid !== 1'b0 || upstreamStall !== 4'hF) begin failures++; $display("[TB] FAIL single_bubble actual valid=%b stall=%b required 0/1111", outValid, upstreamStall); end
    step();
    skipHeader(8'd2);
    checks++; if (outValid !== 1'b1 || outData !== 32'h11) begin failures++; $display("[TB] FAIL single_w0 actual=%h required=00000011", outData); end
    checks++; if (upstreamStall !== 4'b1011) begin failures++; $display("[TB] FAIL single_stall actual=%b required=1011", upstreamStall); end
    step();
    inData[2] = 32'h22;
    #1;
    checks++; if (outData !== 32'h22) begin failures++; $display("[TB] FAIL single_w1 actual=%h required=00000022", outData); end
    step();
    inData[2] = 32'h33; inLast = 4'b0100;
    #1;
    checks++; if (outData !== 32'h33) begin failures++; $display("[TB] FAIL single_w2 actual=%h required=00000033", outData); end
    step();
    clearInputs();
    #1;
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL single_end actual valid=%b required=0", outValid); end
    // All four request now; a pointer of 3 means requester 3 wins.
    inValid = 4'hF; inLast = 4'hF;
    for (int i = 0; i < 4; i++) inData[i] = 32'hC0 + i;
    step();
    skipHeader(8'd3);
    checks++; if (outData !== 32'hC3) begin failures++; $display("[TB] FAIL rrptr_after_req2 actual=%h required=000000c3", outData); end
    step();
    clearInputs();
  endtask

  task automatic test_alternate();
    logic [31:0] expData;
    inValid = 4'b0011; inLast = 4'b0011;
    inData[0] = 32'hA0; inData[1] = 32'hB0;
    for (int p = 0; p < 3; p++) begin
      expData = (p % 2 == 0) ? 32'hA0 : 32'hB0;
      #1;
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL alt_bubble%0d actual valid=%b required=0", p, outValid); end
      step();
      skipHeader(8'(p % 2));
      checks++; if (outValid !== 1'b1 || outData !== expData) begin failures++; $display("[TB] FAIL alt_word%0d actual=%h required=%h", p, outData, expData); end
      step();
    end
    clearInputs();
  endtask

  task automatic test_stall();
    inValid = 4'b0010; inData[1] = 32'h51;
    step();
    skipHeader(8'd1);
    checks++; if (outData !== 32'h51) begin failures++; $display("[TB] FAIL stall_w0 actual=%h required=00000051", outData); end
    step();
    inData[1] = 32'h52; downstreamStall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (outValid !== 1'b1 || outData !== 32'h52 || upstreamStall !== 4'hF) begin failures++; $display("[TB] FAIL stall_hold%0d actual data=%h stall=%b required 00000052/1111", c, outData, upstreamStall); end
      step();
    end
    downstreamStall = 1'b0;
    #1;
    checks++; if (outData !== 32'h52 || upstreamStall !== 4'b1101) begin failures++; $display("[TB] FAIL stall_release actual data=%h stall=%b required 00000052/1101", outData, upstreamStall); end
    step();
    inData[1] = 32'h53; inLast = 4'b0010;
    #1;
    checks++; if (outData !== 32'h53) begin failures++; $display("[TB] FAIL stall_w2 actual=%h required=00000053", outData); end
    step();
    clearInputs();
  endtask

  task automatic test_reset_mid_packet();
    inValid = 4'b1000; inData[3] = 32'h61;
    step();
    skipHeader(8'd3);
    checks++; if (outData !== 32'h61) begin failures++; $display("[TB] FAIL rst_w0 actual=%h required=00000061", outData); end
    step();
    inData[3] = 32'h62;
    #1;
    checks++; if (outData !== 32'h62) begin failures++; $display("[TB] FAIL rst_w1 actual=%h required=00000062", outData); end
    reset = 1'b1;
    step();
    checks++; if (outValid !== 1'b0 || upstreamStall !== 4'hF) begin failures++; $display("[TB] FAIL rst_idle actual valid=%b stall=%b required 0/1111", outValid, upstreamStall); end
    reset = 1'b0;
    // Requester 3 keeps requesting; only a pointer cleared to 0 lets requester 1 win.
    inValid = 4'b1010; inData[1] = 32'h71; inLast = 4'b0010;
    #1;
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_bubble actual valid=%b required=0", outValid); end
    step();
`ifdef PACKET_ARBITER_HEADER_EN
    checks++; if (outData !== 32'hA5010000) begin failures++; $display("[TB] FAIL rst_hdr_seq actual=%h required=a5010000", outData); end
`endif
    skipHeader(8'd1);
    checks++; if (outData !== 32'h71 || upstreamStall !== 4'b1101) begin failures++; $display("[TB] FAIL rst_regrant actual data=%h stall=%b required 00000071/1101", outData, upstreamStall); end
    step();
    clearInputs();
  endtask

`ifdef PACKET_ARBITER_HEADER_EN
  task automatic test_header();
    reset = 1'b1;
    clearInputs();
    step();
    reset = 1'b0;
    inValid = 4'b1000; inLast = 4'b1000; inData[3] = 32'hDEAD;
    step();
    checks++; if (outValid !== 1'b1 || outData !== 32'hA5030000 || upstreamStall !== 4'hF) begin failures++; $display("[TB] FAIL hdr0 actual data=%h stall=%b required a5030000/1111", outData, upstreamStall); end
    step();
    checks++; if (outData !== 32'hDEAD) begin failures++; $display("[TB] FAIL hdr0_payload actual=%h required=0000dead", outData); end
    step();
    downstreamStall = 1'b1;
    step();
    for (int c = 0; c < 2; c++) begin
      checks++; if (outValid !== 1'b1 || outData !== 32'hA5030001 || upstreamStall !== 4'hF) begin failures++; $display("[TB] FAIL hdr1_stall%0d actual data=%h required=a5030001", c, outData); end
      step();
    end
    downstreamStall = 1'b0;
    #1;
    checks++; if (outData !== 32'hA5030001) begin failures++; $display("[TB] FAIL hdr1 actual=%h required=a5030001", outData); end
    step();
    checks++; if (outData !== 32'hDEAD) begin failures++; $display("[TB] FAIL hdr1_payload actual=%h required=0000dead", outData); end
    step();
    clearInputs();
  endtask

  task automatic test_seq_wrap();
    logic [31:0] expHdr;
    reset = 1'b1;
    clearInputs();
    step();
    reset = 1'b0;
    inValid = 4'b0001; inLast = 4'b0001;
    for (int p = 0; p < 17; p++) begin
      inData[0] = 32'(p);
      expHdr = 32'hA5000000 | 32'(p % 16);
      step();
      checks++; if (outData !== expHdr) begin failures++; $display("[TB] FAIL seq_hdr%0d actual=%h required=%h", p, outData, expHdr); end
      step();
      step();
    end
    clearInputs();
  endtask
`endif

  initial begin
    test_reset();
    test_single_source();
    test_alternate();
    test_stall();
    test_reset_mid_packet();
`ifdef PACKET_ARBITER_HEADER_EN
    test_header();
    test_seq_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
